// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and flag controller for the width-converting sync FIFO memory.
// Occupancy is kept in memory words; push beats add W_WORDS and pop beats remove R_WORDS.
module sync_fifo_ctrl #(
    parameter int unsigned R_DATA_WIDTH = 64,
    parameter int unsigned W_DATA_WIDTH = 16,
    parameter int unsigned MEM_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic                  pop,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  unf
);

    localparam int unsigned W_WORDS = W_DATA_WIDTH / MEM_WIDTH;
    localparam int unsigned R_WORDS = R_DATA_WIDTH / MEM_WIDTH;
    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0]      FULL_THR  = CNT_W'(FIFO_DEPTH - W_WORDS);
    localparam logic [CNT_W-1:0]      EMPTY_THR = CNT_W'(R_WORDS);
    localparam logic [CNT_W-1:0]      CNT_INC   = CNT_W'(W_WORDS);
    localparam logic [CNT_W-1:0]      CNT_DEC   = CNT_W'(R_WORDS);
    localparam logic [ADDR_WIDTH-1:0] WR_STEP   = ADDR_WIDTH'(W_WORDS);
    localparam logic [ADDR_WIDTH-1:0] RD_STEP   = ADDR_WIDTH'(R_WORDS);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  push_ok, pop_ok;

    // Flags depend only on the occupancy registered at the start of the cycle.
    assign full    = (count_q > FULL_THR);
    assign empty   = (count_q < EMPTY_THR);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign wr_en   = push_ok & ~flush;
    assign rd_en   = ~empty;
    assign wr_addr = wr_ptr_q;
    assign rd_addr = rd_ptr_q;
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push & full;
        unf_d    = pop & empty;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            // Pointers wrap naturally; depth is a multiple of both beat sizes.
            if (push_ok) wr_ptr_d = wr_ptr_q + WR_STEP;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + RD_STEP;
            count_d = count_q + (push_ok ? CNT_INC : '0) - (pop_ok ? CNT_DEC : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised scoreboard bench for sync_fifo_ctrl with a word-queue reference model
// and a behavioural FIFO memory driven by the controller's write/read addresses.
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 16;
    localparam int W_W   = 1;
    localparam int R_W   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       wr_en, rd_en, full, empty, ovf, unf;
    logic [3:0] wr_addr, rd_addr;
    logic [4:0] count;
    logic [15:0] wdata = '0;
    logic [15:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int count;
        int wr_addr;
        int rd_addr;
        bit full;
        bit empty;
        bit wr_en;
        bit rd_en;
        bit ovf;
        bit unf;
        bit pop_ok;
    } status_t;

    status_t      exp_q[$];
    logic [15:0]  sb[$];

    // Reference model state: occupancy in words, pointers as word positions.
    int m_cnt = 0;
    int m_wp  = 0;
    int m_rp  = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    sync_fifo_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .unf     (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic status_t snapshot(input bit p, input bit q, input bit f);
        status_t e;
        e.count   = m_cnt;
        e.full    = (m_cnt > DEPTH - W_W);
        e.empty   = (m_cnt < R_W);
        e.wr_en   = p && !e.full && !f;
        e.rd_en   = !e.empty;
        e.wr_addr = m_wp;
        e.rd_addr = m_rp;
        e.ovf     = m_ovf;
        e.unf     = m_unf;
        e.pop_ok  = q && !e.empty && !f;
        return e;
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_wp  = 0;
        m_rp  = 0;
        m_ovf = 0;
        m_unf = 0;
        sb.delete();
    endtask

    task automatic cycle(input bit p, input bit q, input bit f);
        status_t e;
        bit      full_now, empty_now;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push  = p;
        pop   = q;
        flush = f;
        wdata = 16'($urandom);
        e = snapshot(p, q, f);
        exp_q.push_back(e);
        full_now  = e.full;
        empty_now = e.empty;
        if (f) begin
            model_clear();
        end else begin
            if (p && !full_now) begin
                sb.push_back(wdata);
                m_cnt += W_W;
                m_wp = (m_wp + W_W) % DEPTH;
            end
            if (q && !empty_now) begin
                m_cnt -= R_W;
                m_rp = (m_rp + R_W) % DEPTH;
            end
            m_ovf = p && full_now;
            m_unf = q && empty_now;
        end
    endtask

    // Reset is raised between clock edges so only an asynchronous clear is visible this cycle.
    task automatic do_reset();
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        model_clear();
        exp_q.push_back(snapshot(1'b0, 1'b0, 1'b0));
    endtask

    // Monitor: compare the presented status, check popped data, then perform the negedge write.
    always @(negedge clk) begin : monitor
        status_t     e;
        int          idx;
        logic [15:0] exp_word;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count",   32'(count),   32'(e.count));
            chk("full",    32'(full),    32'(e.full));
            chk("empty",   32'(empty),   32'(e.empty));
            chk("wr_en",   32'(wr_en),   32'(e.wr_en));
            chk("rd_en",   32'(rd_en),   32'(e.rd_en));
            chk("wr_addr", 32'(wr_addr), 32'(e.wr_addr));
            chk("rd_addr", 32'(rd_addr), 32'(e.rd_addr));
            chk("ovf",     32'(ovf),     32'(e.ovf));
            chk("unf",     32'(unf),     32'(e.unf));
            if (e.pop_ok) begin
                for (int i = 0; i < R_W; i++) begin
                    idx = (int'(rd_addr) + i) % DEPTH;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underrun: got pop with no queued data, required queued data");
                    end else begin
                        exp_word = sb.pop_front();
                        chk("rd_data", 32'(mem[idx]), 32'(exp_word));
                    end
                end
            end
        end
        if (wr_en) mem[wr_addr] = wdata;
    end

    initial begin
        // Reset values
        do_reset();
        // Four pushes from empty, then idle to see rd_en rise
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        cycle(0, 0, 0);
        // Fill to full, one refused push, observe ovf pulse
        do_reset();
        for (int i = 0; i < 17; i++) cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        // Pop below one read beat
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        // Simultaneous push and pop, then push refused at full while pop proceeds
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        cycle(1, 1, 0);
        for (int i = 0; i < 15; i++) cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(0, 0, 0);
        // Steady streaming across several pointer wraps
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, (i % 4) == 3, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        // Flush at count 9 with a push pending, then reset in the middle of a burst
        do_reset();
        for (int i = 0; i < 9; i++) cycle(1, 0, 0);
        cycle(1, 1, 1);
        cycle(0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 0);
        do_reset();
        cycle(0, 0, 0);
        // Random traffic with occasional flush and reset
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 63) == 0);
        end
        cycle(0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
